// File: rtl/sram_req_arbiter_if.sv
// Strobe/busy bus between the request arbiter (master) and the SRAM controller (slave).
interface sram_req_arbiter_if;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;

  logic          ctl_read;
  logic          ctl_write;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_din;
  logic [1:0]    ctl_byte_sel;
  logic [DW-1:0] ctl_dout;
  logic          ctl_busy;

  modport master (
    output ctl_read, ctl_write, ctl_addr, ctl_din, ctl_byte_sel,
    input  ctl_dout, ctl_busy
  );

  modport slave (
    input  ctl_read, ctl_write, ctl_addr, ctl_din, ctl_byte_sel,
    output ctl_dout, ctl_busy
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Merges loader/CPU/PPU byte requests onto one SRAM controller strobe bus, fixed priority.
// Optional per-requester completion counters are enabled with `define SRAM_ARB_STATS_EN.
module sram_req_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TW      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_write,
  input  logic [21:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        ppu_read,
  input  logic [21:0] ppu_addr,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  ppu_rdata,
  output logic        cpu_ack,
  output logic        ppu_ack,
  output logic        ld_ack,
  output logic        overrun,
  output logic        timeout_err,
  sram_req_arbiter_if.master ctl
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0] stat_ld,
  output logic [15:0] stat_cpu,
  output logic [15:0] stat_ppu
`endif
);

  localparam int unsigned SW = 21;  // mapped SRAM byte address width
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {IDLE, STROBE, WAIT_HI, WAIT_LO, ABORT, RESP} state_t;
  typedef enum logic [1:0] {G_LD, G_PPU, G_CPU} gnt_t;

  state_t state, state_nxt;
  gnt_t   gnt, sel_gnt;
  logic   gnt_rd;

  logic          ld_pend, cpu_pend, ppu_pend;
  logic [SW-1:0] ld_a, cpu_a, ppu_a;
  logic [DW-1:0] ld_d, cpu_d;
  logic          cpu_wr;

  logic [SW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_rd;

  logic          grant, capture, abort;
  logic [TW-1:0] timer;
  logic          timer_hit;

  logic ld_req, cpu_req, ppu_req;
  logic ld_clr, cpu_clr, ppu_clr;

  // addr[20] is not part of the SRAM map
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[20], cpu_addr[20], ppu_addr[20]};

  function automatic logic [SW-1:0] map_addr(input logic [21:0] a);
    return {a[21], a[19:0]};
  endfunction

  assign ld_req  = ld_write;
  assign cpu_req = cpu_read | cpu_write;
  assign ppu_req = ppu_read;

  assign ld_clr  = (state == RESP) && (gnt == G_LD);
  assign cpu_clr = (state == RESP) && (gnt == G_CPU);
  assign ppu_clr = (state == RESP) && (gnt == G_PPU);

  assign timer_hit = (timer == TW'(TIMEOUT));

  // Pending slots: a new request is taken when the slot is free or completing this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_pend  <= 1'b0;
      cpu_pend <= 1'b0;
      ppu_pend <= 1'b0;
      ld_a     <= '0;
      cpu_a    <= '0;
      ppu_a    <= '0;
      ld_d     <= '0;
      cpu_d    <= '0;
      cpu_wr   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (ld_req && (!ld_pend || ld_clr)) begin
        ld_pend <= 1'b1;
        ld_a    <= map_addr(ld_addr);
        ld_d    <= ld_data;
      end else if (ld_clr) begin
        ld_pend <= 1'b0;
      end

      if (cpu_req && (!cpu_pend || cpu_clr)) begin
        cpu_pend <= 1'b1;
        cpu_a    <= map_addr(cpu_addr);
        cpu_d    <= cpu_wdata;
        cpu_wr   <= cpu_write;
      end else if (cpu_clr) begin
        cpu_pend <= 1'b0;
      end

      if (ppu_req && (!ppu_pend || ppu_clr)) begin
        ppu_pend <= 1'b1;
        ppu_a    <= map_addr(ppu_addr);
      end else if (ppu_clr) begin
        ppu_pend <= 1'b0;
      end

      if ((ld_req && ld_pend && !ld_clr) || (cpu_req && cpu_pend && !cpu_clr) ||
          (ppu_req && ppu_pend && !ppu_clr))
        overrun <= 1'b1;
    end
  end

  // Fixed priority select: loader > PPU > CPU
  always_comb begin
    sel_gnt  = G_LD;
    sel_addr = ld_a;
    sel_data = ld_d;
    sel_rd   = 1'b0;
    if (!ld_pend) begin
      if (ppu_pend) begin
        sel_gnt  = G_PPU;
        sel_addr = ppu_a;
        sel_data = '0;
        sel_rd   = 1'b1;
      end else begin
        sel_gnt  = G_CPU;
        sel_addr = cpu_a;
        sel_data = cpu_d;
        sel_rd   = !cpu_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (ld_pend || ppu_pend || cpu_pend) begin
          grant     = 1'b1;
          state_nxt = STROBE;
        end
      end
      STROBE: state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (ctl.ctl_busy)   state_nxt = WAIT_LO;
        else if (timer_hit) state_nxt = ABORT;
      end
      WAIT_LO: begin
        if (!ctl.ctl_busy) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (timer_hit) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        abort     = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Controller bus, timer, acks and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt              <= G_LD;
      gnt_rd           <= 1'b0;
      ctl.ctl_read     <= 1'b0;
      ctl.ctl_write    <= 1'b0;
      ctl.ctl_addr     <= '0;
      ctl.ctl_din      <= '0;
      ctl.ctl_byte_sel <= '0;
      timer            <= '0;
      ld_ack           <= 1'b0;
      cpu_ack          <= 1'b0;
      ppu_ack          <= 1'b0;
      cpu_rdata        <= '0;
      ppu_rdata        <= '0;
      timeout_err      <= 1'b0;
    end else begin
      ctl.ctl_read  <= grant && sel_rd;
      ctl.ctl_write <= grant && !sel_rd;
      if (grant) begin
        gnt              <= sel_gnt;
        gnt_rd           <= sel_rd;
        ctl.ctl_addr     <= {3'b000, sel_addr};
        ctl.ctl_din      <= sel_data;
        ctl.ctl_byte_sel <= sel_addr[1:0];
      end

      if (state == STROBE)
        timer <= '0;
      else if ((state == WAIT_HI || state == WAIT_LO) && !timer_hit)
        timer <= timer + TW'(1);

      ld_ack  <= (capture || abort) && (gnt == G_LD);
      cpu_ack <= (capture || abort) && (gnt == G_CPU);
      ppu_ack <= (capture || abort) && (gnt == G_PPU);

      if ((capture || abort) && gnt_rd) begin
        if (gnt == G_CPU) cpu_rdata <= abort ? 8'hFF : ctl.ctl_dout;
        if (gnt == G_PPU) ppu_rdata <= abort ? 8'hFF : ctl.ctl_dout;
      end

      if (abort) timeout_err <= 1'b1;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // Saturating completion counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ld  <= '0;
      stat_cpu <= '0;
      stat_ppu <= '0;
    end else begin
      if (ld_ack  && stat_ld  != 16'hFFFF) stat_ld  <= stat_ld  + 16'd1;
      if (cpu_ack && stat_cpu != 16'hFFFF) stat_cpu <= stat_cpu + 16'd1;
      if (ppu_ack && stat_ppu != 16'hFFFF) stat_ppu <= stat_ppu + 16'd1;
    end
  end
`endif

endmodule
